// File: rtl/matrix_fifo_mover_if.sv
// Memory write port of the matrix mover: valid/address/data from the mover, ready back
// from the memory.
interface matrix_fifo_mover_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 8
);
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_ready;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/matrix_fifo_mover.sv
// Snapshots a ROWS x COLS matrix on start and streams it through a show-ahead FIFO into a
// memory write port, in fill/drain chunks when the matrix is larger than the FIFO.
module matrix_fifo_mover #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter bit          COL_MAJOR      = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic                               start_i,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0]    matrix_i,
    input  logic [MEM_ADDR_WIDTH-1:0]          base_addr_i,
    matrix_fifo_mover_if.master                mem_if,
    output logic                               busy_o,
    output logic                               done_o
);
    localparam int unsigned N      = ROWS * COLS;
    localparam int unsigned CntW   = $clog2(N + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCntW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

    state_e                      state_q;
    logic [N*DATA_WIDTH-1:0]     ordered;
    logic [N*DATA_WIDTH-1:0]     mat_q;
    logic [MEM_ADDR_WIDTH-1:0]   base_q;
    logic [CntW-1:0]             push_cnt_q;
    logic [CntW-1:0]             wr_cnt_q;
    logic [DATA_WIDTH-1:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]             wr_ptr_q;
    logic [PtrW-1:0]             rd_ptr_q;
    logic [FCntW-1:0]            fcnt_q;
    logic                        busy_q;
    logic                        done_q;
    logic [DATA_WIDTH-1:0]       push_data;
    logic                        drain;
    logic                        xfer;

    // Reorder at capture time so the push path is a plain linear index in either mode.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned Idx = COL_MAJOR ? c * ROWS + r : r * COLS + c;
            assign ordered[Idx*DATA_WIDTH +: DATA_WIDTH] =
                matrix_i[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign push_data = mat_q[32'(push_cnt_q) * DATA_WIDTH +: DATA_WIDTH];
    assign drain     = (state_q == StDrain);
    assign xfer      = drain && (fcnt_q != '0) && mem_if.mem_ready;

    assign mem_if.mem_we    = drain && (fcnt_q != '0);
    assign mem_if.mem_addr  = drain ? base_q + MEM_ADDR_WIDTH'(wr_cnt_q) : '0;
    assign mem_if.mem_wdata = drain ? fifo_mem_q[rd_ptr_q] : '0;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

    always_ff @(posedge clk_i) begin
        if (state_q == StFill) begin
            fifo_mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            mat_q      <= '0;
            base_q     <= '0;
            push_cnt_q <= '0;
            wr_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mat_q      <= ordered;
                        base_q     <= base_addr_i;
                        push_cnt_q <= '0;
                        wr_cnt_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StFill;
                    end
                end
                StFill: begin
                    wr_ptr_q   <= wr_ptr_q + 1'b1;
                    fcnt_q     <= fcnt_q + 1'b1;
                    push_cnt_q <= push_cnt_q + 1'b1;
                    if (fcnt_q == FCntW'(FIFO_DEPTH - 1) || push_cnt_q == CntW'(N - 1)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (xfer) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        fcnt_q   <= fcnt_q - 1'b1;
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        // Turn around on the emptying transfer itself so no bubble appears.
                        if (fcnt_q == FCntW'(1)) begin
                            state_q <= (wr_cnt_q == CntW'(N - 1)) ? StDone : StFill;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/matrix_fifo_mover.md
# matrix_fifo_mover

Parametrised successor to the single-shot FIFO transfer stage. On `start` it snapshots a ROWS×COLS result matrix from the dot-product stage and streams it element by element through an internal synchronous FIFO into a dual-port memory write port. Matrices larger than the FIFO are moved in fill/drain chunks. The block supports row- or column-major ordering, a base address, and memory back-pressure, and signals completion with a one-cycle `done`.

## Interface
- `DATA_WIDTH`, default 32: element width in bits.
- `ROWS`, default 4: matrix rows, ≥1.
- `COLS`, default 4: matrix columns, ≥1.
- `FIFO_DEPTH`, default 16: internal FIFO entries; power of two, ≥2.
- `MEM_ADDR_WIDTH`, default 8: memory address width.
- `COL_MAJOR`, default 0: 0 = row-major order, 1 = column-major order.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: request transfer; sampled only in IDLE.
- `matrix_in` in ROWS*COLS*DATA_WIDTH: flattened matrix, element (r,c) at bits [(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH].
- `base_addr` in MEM_ADDR_WIDTH: first write address; captured with `start`.
- `mem_ready` in 1: memory accepts the write this cycle.
- `mem_we` out 1: write valid.
- `mem_addr` out MEM_ADDR_WIDTH: write address.
- `mem_wdata` out DATA_WIDTH: write data.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- N = ROWS*COLS elements. Element index i follows the ordering mode: row-major i = r*COLS+c; column-major i = c*ROWS+r.
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - On `start`=1, capture `matrix_in` and `base_addr` into registers, clear the push and write counters, go to FILL.
  - `start` is ignored in every other state. Input changes after capture have no effect.
- FILL:
  - Push element[push_cnt] each cycle and increment push_cnt.
  - Go to DRAIN on the edge where the push fills the FIFO or push_cnt reaches N.
- DRAIN:
  - The FIFO is show-ahead. `mem_wdata` = FIFO head; `mem_we` = !fifo_empty.
  - A transfer occurs when `mem_we` && `mem_ready`. It pops the FIFO and increments wr_cnt.
  - `mem_addr` = base_addr + wr_cnt, truncated to MEM_ADDR_WIDTH (wraps modulo 2^MEM_ADDR_WIDTH).
  - On the transfer that empties the FIFO: go to DONE if wr_cnt+1 = N, else back to FILL. There is no bubble cycle.
- DONE: `done`=1 for one cycle, then IDLE.
- No push occurs in DRAIN and no pop occurs in FILL, so the FIFO never sees a simultaneous push and pop. The FIFO never overflows: FILL stops at full. The FIFO never underflows: there is no pop when empty.
- Counters are $clog2(N+1) bits wide. Addresses wrap silently.

## Timing
- Reset (`reset`=0 at a rising edge): state IDLE, FIFO emptied, counters cleared. `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0.
- Reset mid-transfer aborts immediately. No further `mem_we` is issued, and no `done` is issued for the aborted transfer.
- `start` sampled at edge k: `busy`=1 from edge k.
- Latency with `mem_ready` held at 1: `done` is high in the cycle following edge k+2N+1. This holds for any FIFO_DEPTH because chunk turnarounds cost no cycles.
- Each cycle with `mem_ready`=0 in DRAIN adds one cycle. During such stalls `mem_we`, `mem_addr` and `mem_wdata` hold steady.
- `mem_ready` is a don't-care outside DRAIN.
- `done` and `busy` are registered outputs. `mem_we`, `mem_addr` and `mem_wdata` derive from registered state and FIFO head only, with no combinational path from `mem_ready` to them.

## Test plan
- Defaults, matrix element (r,c) = 10*r+c, base 0x00, `mem_ready`=1 -> 16 writes: addr 0x00..0x0F carrying 0,1,2,3,10,...,33 in order; `done` at cycle k+34; `busy` low afterwards.
- FIFO_DEPTH=4, same matrix -> 4 chunks of 4 writes; the same 16 address/data pairs in order; `done` still at k+34.
- COL_MAJOR=1 -> write data 0,10,20,30,1,11,...,33 at addr 0..15.
- base_addr=0xFC, MEM_ADDR_WIDTH=8 -> addresses 0xFC,0xFD,0xFE,0xFF,0x00,...,0x0B.
- `mem_ready` toggling 1,0,0,1,... -> data/address held through stalls; no element lost or duplicated; `done` delayed by exactly the count of stalled DRAIN cycles.
- `start` re-asserted while busy, then `reset`=0 at write 5 -> second `start` ignored; after reset `mem_we`=0, `done` never pulses, `busy`=0. A fresh `start` then completes normally from element 0.
